// File: rtl/param_sync_fifo_pkg.sv
// rtl/param_sync_fifo_pkg.sv - shared defaults and width helper for param_sync_fifo
//
// Purpose: default geometry of the FIFO and the occupancy-counter width helper.
// Contents:
//   DEF_DATA_W  default data word width
//   DEF_DEPTH   default number of entries (power of two)
//   cnt_width() bits needed to hold an occupancy of 0..depth

package param_sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // A power-of-two depth needs one bit beyond the address width so that the
  // "completely full" value DEPTH is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_mem.sv
// rtl/param_sync_fifo_mem.sv - storage array for param_sync_fifo
//
// Purpose: DEPTH x DATA_W register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk_i  clock, writes on rising edge
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, combinational from raddr

module fifo_mem
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with flags and flush
//
// Purpose: rate-smoothing buffer between same-clock producer and consumer.
// Build option: define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through
// reads; default is a registered read with a one-cycle rvalid_o pulse.
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   clr_i           synchronous flush of pointers, count and sticky flags
//   wdata_i/wr_en_i write data / request
//   rd_en_i         read request (FWFT: pop of the presented word)
//   rdata_o         read data
//   rvalid_o        rdata_o valid
//   full_o/empty_o  count_o == DEPTH / count_o == 0
//   almost_full_o   count_o >= AF_LEVEL
//   almost_empty_o  count_o <= AE_LEVEL
//   count_o         stored entries 0..DEPTH
//   overflow_o      sticky: write attempted while full
//   underflow_o     sticky: read attempted while empty

module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic                   wr_en_i,
  input  logic                   rd_en_i,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   rvalid_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              ovf_q;
  logic              unf_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_acc;
  logic              rd_acc;

  // A flush wins over any same-cycle request; otherwise the full/empty
  // gating alone resolves the simultaneous read+write corner cases.
  assign wr_acc = wr_en_i && !full_o  && !clr_i;
  assign rd_acc = rd_en_i && !empty_o && !clr_i;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i (clk_i),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wdata_i),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      // Pointers wrap naturally at AW bits because DEPTH is a power of two.
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (wr_en_i && full_o)  ovf_q <= 1'b1;
      if (rd_en_i && empty_o) unf_q <= 1'b1;
    end
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // Head word is always presented; a pop simply advances rd_ptr_q.
  assign rdata_o  = mem_rdata;
  assign rvalid_o = !empty_o;
`else
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  // rdata_q deliberately keeps its value on flush and between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (clr_i) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem_rdata;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
`endif

  assign count_o        = count_q;
  assign full_o         = (count_q == FULL_C);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - self-checking directed bench for param_sync_fifo

module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk_i   = 1'b0;
  logic          rst_i   = 1'b1;
  logic          clr_i   = 1'b0;
  logic [DW-1:0] wdata_i = '0;
  logic          wr_en_i = 1'b0;
  logic          rd_en_i = 1'b0;
  logic [DW-1:0] rdata_o;
  logic          rvalid_o;
  logic          full_o;
  logic          empty_o;
  logic          almost_full_o;
  logic          almost_empty_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic          underflow_o;

  param_sync_fifo dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (clr_i),
    .wdata_i        (wdata_i),
    .wr_en_i        (wr_en_i),
    .rd_en_i        (rd_en_i),
    .rdata_o        (rdata_o),
    .rvalid_o       (rvalid_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf    = 0;
  bit            m_unf    = 0;
  bit            m_rvalid = 0;
  logic [DW-1:0] m_rdata  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"}, 32'(count_o), 32'(n));
    check({tag, ".full"},  32'(full_o),  32'(n == DEPTH));
    check({tag, ".empty"}, 32'(empty_o), 32'(n == 0));
    check({tag, ".af"},    32'(almost_full_o),  32'(n >= DEPTH - 2));
    check({tag, ".ae"},    32'(almost_empty_o), 32'(n <= 2));
    check({tag, ".ovf"},   32'(overflow_o),  32'(m_ovf));
    check({tag, ".unf"},   32'(underflow_o), 32'(m_unf));
    check({tag, ".rvalid"}, 32'(rvalid_o), 32'(m_rvalid));
    if (m_rvalid) check({tag, ".rdata"}, 32'(rdata_o), 32'(m_rdata));
  endtask

  // One clock of stimulus; the model is advanced from the pre-edge state.
  task automatic cyc(input bit wr, input logic [DW-1:0] wd, input bit rd,
                     input bit clr, input string tag);
    bit full, empty;
    full    = (q.size() == DEPTH);
    empty   = (q.size() == 0);
    wr_en_i = wr;
    wdata_i = wd;
    rd_en_i = rd;
    clr_i   = clr;
    @(posedge clk_i);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    clr_i   = 1'b0;
    if (clr) begin
      q.delete();
      m_ovf    = 0;
      m_unf    = 0;
      m_rvalid = 0;
    end else begin
      if (wr && full)  m_ovf = 1;
      if (rd && empty) m_unf = 1;
      m_rvalid = rd && !empty;
      if (rd && !empty) m_rdata = q.pop_front();
      if (wr && !full)  q.push_back(wd);
    end
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    m_rvalid = (q.size() != 0);
    if (m_rvalid) m_rdata = q[0];
`endif
    check_state(tag);
  endtask

  initial begin
    int wi;
    logic [DW-1:0] d;

    // Reset then idle
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_state("rst");
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("rst.rdata", 32'(rdata_o), 32'h0);
`endif
    cyc(0, 8'h00, 0, 0, "idle");

    // Fill to full, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'(i), 0, 0, $sformatf("fill%0d", i));
    check("fill.full", 32'(full_o), 32'h1);
    cyc(1, 8'hAA, 0, 0, "ovf_wr");
    check("ovf.flag", 32'(overflow_o), 32'h1);
    check("ovf.count", 32'(count_o), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 8'h00, 1, 0, $sformatf("drain%0d", i));
`ifndef PARAM_SYNC_FIFO_FWFT_EN
      check($sformatf("drain%0d.val", i), 32'(rdata_o), 32'(i));
`endif
    end
    check("drain.empty", 32'(empty_o), 32'h1);
    cyc(0, 8'h00, 0, 1, "clr0");

    // Interleaved traffic with pointer wrap
    wi = 0;
    for (int i = 0; i < 300 && (wi < 40 || q.size() != 0); i++) begin
      bit w, acc;
      w   = (wi < 40);
      acc = w && (q.size() != DEPTH);
      cyc(w, DW'(8'h30 + wi), (i % 4) != 0, 0, $sformatf("il%0d", i));
      if (acc) wi++;
    end
    check("il.written", 32'(wi), 32'd40);
    check("il.empty", 32'(empty_o), 32'h1);
    cyc(0, 8'h00, 0, 1, "clr1");

    // Full with simultaneous read and write
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'(8'h80 + i), 0, 0, $sformatf("f2_%0d", i));
    cyc(1, 8'hBB, 1, 0, "full_rw");
    check("full_rw.count", 32'(count_o), 32'd15);
    check("full_rw.ovf", 32'(overflow_o), 32'h1);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 8'h00, 1, 0, $sformatf("d2_%0d", i));
    cyc(0, 8'h00, 0, 1, "clr2");

    // Empty with simultaneous read and write
    cyc(1, 8'hCC, 1, 0, "empty_rw");
    check("empty_rw.count", 32'(count_o), 32'd1);
    check("empty_rw.unf", 32'(underflow_o), 32'h1);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("empty_rw.rvalid", 32'(rvalid_o), 32'h0);
`endif
    cyc(0, 8'h00, 1, 0, "rd_cc");
    check("rd_cc.val", 32'(rdata_o), 32'hCC);

    // Flush with a concurrent write
    for (int i = 0; i < 5; i++) cyc(1, DW'(8'h40 + i), 0, 0, $sformatf("f5_%0d", i));
    d = m_rdata;
    cyc(1, 8'hEE, 0, 1, "clr_wr");
    check("clr.count", 32'(count_o), 32'd0);
    check("clr.empty", 32'(empty_o), 32'h1);
    check("clr.unf", 32'(underflow_o), 32'h0);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("clr.rdata_held", 32'(rdata_o), 32'(d));
`endif
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    cyc(1, 8'h5A, 0, 0, "fwft_wr");
    check("fwft.rvalid", 32'(rvalid_o), 32'h1);
    check("fwft.rdata", 32'(rdata_o), 32'h5A);
    cyc(0, 8'h00, 1, 0, "fwft_rd");
    check("fwft.rvalid_after", 32'(rvalid_o), 32'h0);
`else
    cyc(1, 8'h77, 0, 0, "post_clr_wr");
    cyc(0, 8'h00, 1, 0, "post_clr_rd");
    check("post_clr.val", 32'(rdata_o), 32'h77);
`endif

    // Asynchronous reset asserted between edges mid-transfer
    cyc(1, 8'h11, 0, 0, "pre_rst0");
    cyc(1, 8'h22, 0, 0, "pre_rst1");
    cyc(1, 8'h33, 1, 0, "pre_rst2");
    wr_en_i = 1'b1;
    wdata_i = 8'h44;
    #2;
    rst_i = 1'b1;
    #1;
    wr_en_i = 1'b0;
    q.delete();
    m_ovf    = 0;
    m_unf    = 0;
    m_rvalid = 0;
    m_rdata  = '0;
    check_state("async_rst");
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    check("async_rst.rdata", 32'(rdata_o), 32'h0);
`endif
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc(1, 8'h99, 0, 0, "post_rst_wr");
    cyc(0, 8'h00, 1, 0, "post_rst_rd");
    check("post_rst.val", 32'(rdata_o), 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO, the next generation of the team's 8-bit/16-entry synchronous FIFO. Adds configurable data width and depth, a full-width occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, a synchronous flush and an optional first-word-fall-through read mode. It sits between same-clock producer/consumer blocks as the general-purpose rate-smoothing buffer.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full_o asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty_o asserts when count ≤ AE_LEVEL
- Derived: AW = $clog2(DEPTH), CW = AW+1
- clk_i  in  1  the single clock; all logic on its rising edge
- rst_i  in  1  reset; one clock, reset is asynchronous and active-high
- clr_i  in  1  synchronous flush, high for one or more cycles
- wdata_i  in  DATA_W  write data
- wr_en_i  in  1  write request
- rd_en_i  in  1  read request (FWFT: acknowledge of the head word)
- rdata_o  out  DATA_W  read data
- rvalid_o  out  1  rdata_o is valid
- full_o / empty_o  out  1  count==DEPTH / count==0
- almost_full_o / almost_empty_o  out  1  threshold flags
- count_o  out  CW  stored entries, 0..DEPTH
- overflow_o / underflow_o  out  1  sticky error flags

## Operation
- Write accepted (wr_acc) iff wr_en_i && !full_o; word goes to mem[wr_ptr], wr_ptr increments mod DEPTH (natural AW-bit wrap).
- Read accepted (rd_acc) iff rd_en_i && !empty_o; rd_ptr increments mod DEPTH.
- count_o: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- Full and simultaneous read+write: read accepted, write dropped, overflow_o set. Empty and simultaneous read+write: write accepted, read dropped, underflow_o set (no bypass).
- overflow_o set by wr_en_i && full_o; underflow_o set by rd_en_i && empty_o. Both sticky until rst_i or clr_i.
- clr_i: pointers, count, rvalid_o, overflow_o, underflow_o to reset values; rdata_o held; any same-cycle wr/rd ignored. Memory contents not cleared.
- Flags are combinational decodes of count_o.

## Timing
- Reset values: rdata_o 0, rvalid_o 0, count_o 0, empty_o 1, full_o 0, almost_empty_o 1, almost_full_o (AF_LEVEL==0), overflow_o 0, underflow_o 0. Memory not reset.
- Standard mode: rd_acc in cycle N -> rdata_o = head word and rvalid_o=1 in N+1; rvalid_o is a one-cycle pulse per accepted read; rdata_o holds its last value otherwise (no zeroing).
- Count/flags update the cycle after wr_acc/rd_acc. Write in cycle N readable (empty_o low) from N+1.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous); no partial pointer update.

## Configuration
- PARAM_SYNC_FIFO_FWFT_EN defined: first-word-fall-through. rdata_o = mem[rd_ptr] combinationally, rvalid_o = !empty_o; rd_en_i pops the presented word; next word visible the cycle after rd_acc. Reset/clr: rvalid_o 0.
- Not defined: standard registered-read mode above.

## Structure
- Package param_sync_fifo_pkg: default DATA_W/DEPTH constants and a clog2-based width helper; no typedefs needed elsewhere.
- Sub-module fifo_mem: DEPTH×DATA_W register array, one write port (we, waddr, wdata), one asynchronous read port (raddr, rdata); no reset.
- Top holds pointers, counter, flags, read register and mode mux.

## Test plan
- Reset then idle -> empty_o 1, count_o 0, rvalid_o 0, rdata_o 0, all error flags 0.
- DEPTH=16: write 0x00..0x0F -> full_o 1 after 16th, almost_full_o from count 14; 17th write (0xAA) -> overflow_o 1, count stays 16; read all 16 -> 0x00..0x0F in order, then empty_o 1.
- Write 40 words with interleaved reads (pointer wrap ≥2 times) -> output sequence equals input sequence, count_o matches model every cycle.
- Full + simultaneous wr/rd -> count 15, write dropped, overflow_o 1; empty + simultaneous wr/rd -> count 1, underflow_o 1, rvalid_o 0.
- Fill 5 words, pulse clr_i with wr_en_i high -> count_o 0, empty_o 1, flags cleared, next write/read returns new data only.
- FWFT build: write 0x5A to empty FIFO -> next cycle rvalid_o 1, rdata_o 0x5A without rd_en_i; rd_en_i -> rvalid_o 0 following cycle.
